// File: rtl/systolic_result_drain.sv
// Result drain for three 4x4 systolic arrays (INT x INT, INT x Frac, Frac x INT).
// On a rising edge of done, the combined Q.WIDTH value of every element is captured.
// The 16 values are then streamed row-major over a valid/ready handshake.

// Per-element combine: (sext(int) << WIDTH) + sext(frac1) + sext(frac2) at OUT_W bits
module srd_combine #(
   parameter int WIDTH = 8,
   parameter int OUT_W = 3*WIDTH+1
) (
   input  logic [2*WIDTH-1:0] int_p,
   input  logic [2*WIDTH-1:0] frac1_p,
   input  logic [2*WIDTH-1:0] frac2_p,
   output logic [OUT_W-1:0]   sum
);
   logic [OUT_W-1:0] int_x, frac1_x, frac2_x;

   // Sign-extend every product to the full output width before adding, so no bits are lost
   always_comb begin
      int_x   = {{(OUT_W-2*WIDTH){int_p[2*WIDTH-1]}},   int_p};
      frac1_x = {{(OUT_W-2*WIDTH){frac1_p[2*WIDTH-1]}}, frac1_p};
      frac2_x = {{(OUT_W-2*WIDTH){frac2_p[2*WIDTH-1]}}, frac2_p};
      sum     = (int_x << WIDTH) + frac1_x + frac2_x;
   end
endmodule

module systolic_result_drain #(
   parameter int WIDTH = 8,
   parameter int OUT_W = 3*WIDTH+1
) (
   input  logic                    clk,
   input  logic                    _reset,
   input  logic                    done,
   input  logic [16*2*WIDTH-1:0]   res_int,
   input  logic [16*2*WIDTH-1:0]   res_frac1,
   input  logic [16*2*WIDTH-1:0]   res_frac2,
   input  logic                    out_ready,
   input  logic                    clr_overrun,
   output logic                    out_valid,
   output logic [OUT_W-1:0]        out_data,
   output logic [1:0]              out_row,
   output logic [1:0]              out_col,
   output logic                    out_last,
   output logic                    frame_done,
   output logic                    busy,
   output logic                    overrun
);
   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t                    state, state_d;
   logic [3:0]                idx, idx_d;
   logic                      done_q;
   logic                      rise;
   logic                      capture;
   logic                      set_ovr;
   logic                      frame_done_d;
   logic [15:0][OUT_W-1:0]    comb_val;
   logic [15:0][OUT_W-1:0]    frame_buf;

   assign rise = done & ~done_q;

   for (genvar e = 0; e < 16; e++) begin : g_elem
      srd_combine #(.WIDTH(WIDTH), .OUT_W(OUT_W)) u_comb (
         .int_p   (res_int  [e*2*WIDTH +: 2*WIDTH]),
         .frac1_p (res_frac1[e*2*WIDTH +: 2*WIDTH]),
         .frac2_p (res_frac2[e*2*WIDTH +: 2*WIDTH]),
         .sum     (comb_val[e])
      );
   end

   // Next-state logic: a rise in IDLE captures; a rise in STREAM (including the last beat) is dropped
   always_comb begin
      state_d      = state;
      idx_d        = idx;
      capture      = 1'b0;
      set_ovr      = 1'b0;
      frame_done_d = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               capture = 1'b1;
               idx_d   = 4'd0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (rise) set_ovr = 1'b1;
            if (out_ready) begin
               idx_d = idx + 4'd1;
               if (idx == 4'd15) begin
                  state_d      = IDLE;
                  frame_done_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, index, edge detect, completion pulse and sticky overrun (set beats clear)
   always_ff @(posedge clk) begin
      if (_reset) begin
         state      <= IDLE;
         idx        <= 4'd0;
         done_q     <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_d;
         idx        <= idx_d;
         done_q     <= done;
         frame_done <= frame_done_d;
         if (set_ovr)          overrun <= 1'b1;
         else if (clr_overrun) overrun <= 1'b0;
      end
   end

   // Frame buffer holds the captured values; it is never read outside STREAM so it needs no reset
   always_ff @(posedge clk) begin
      if (!_reset && capture) frame_buf <= comb_val;
   end

   // Outputs come straight from state and index, so they hold while stalled and read zero when idle
   always_comb begin
      out_valid = (state == STREAM);
      busy      = (state != IDLE);
      out_data  = '0;
      out_row   = 2'd0;
      out_col   = 2'd0;
      out_last  = 1'b0;
      if (out_valid) begin
         out_data = frame_buf[idx];
         out_row  = idx[3:2];
         out_col  = idx[1:0];
         out_last = (idx == 4'd15);
      end
   end
endmodule

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width of the 4x4 systolic arrays.
REQ-002 The module SHALL have parameter OUT_W, default 3*WIDTH+1, giving the combined output word width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 _reset  input  1  synchronous, active-high reset.
REQ-005 done  input  1  level from the three arrays (done1 & done2 & done3); results are valid while high.
REQ-006 res_int  input  16*2*WIDTH  INT x INT products, signed; element (r,c) at bits [(r*4+c)*2*WIDTH +: 2*WIDTH].
REQ-007 res_frac1  input  16*2*WIDTH  INT x Frac products, signed; same packing as res_int.
REQ-008 res_frac2  input  16*2*WIDTH  Frac x INT products, signed; same packing as res_int.
REQ-009 out_ready  input  1  downstream accepts a beat.
REQ-010 clr_overrun  input  1  clears the overrun flag.
REQ-011 out_valid  output  1  a beat is presented.
REQ-012 out_data  output  OUT_W  combined signed element value.
REQ-013 out_row  output  2  row index of the beat.
REQ-014 out_col  output  2  column index of the beat.
REQ-015 out_last  output  1  high on the beat with row 3, column 3.
REQ-016 frame_done  output  1  one-cycle pulse after the 16th handshake.
REQ-017 busy  output  1  high while not in IDLE.
REQ-018 overrun  output  1  sticky; set when a capture request is dropped.

Function
REQ-019 The module SHALL detect a rising edge of done as: done is 1 and the registered previous value of done is 0.
REQ-020 The FSM SHALL have two states, IDLE and STREAM.
REQ-021 In IDLE, on a done rising edge, the module SHALL capture all 16 elements into a 16 x OUT_W buffer, set idx to 0 and enter STREAM.
REQ-022 The combine rule SHALL be (sext(int) <<< WIDTH) + sext(frac1) + sext(frac2), computed at OUT_W bits; the result is Q.WIDTH fixed point with no saturation or truncation.
REQ-023 The first beat SHALL appear with out_valid = 1 on the cycle after the capture edge; capture-to-first-valid latency is 1 cycle.
REQ-024 In STREAM, out_valid SHALL be 1 and out_data, out_row and out_col SHALL show buffer[idx], idx[3:2] and idx[1:0]; beats are in row-major order.
REQ-025 A beat SHALL transfer only when out_valid and out_ready are both 1; on transfer idx increments.
REQ-026 While out_valid = 1 and out_ready = 0, out_data, out_row, out_col and out_last SHALL hold stable.
REQ-027 On transfer of idx 15, the module SHALL return to IDLE, deassert out_valid on the next cycle and pulse frame_done for exactly that one cycle.
REQ-028 The stream SHALL produce exactly 16 beats per frame regardless of backpressure; out_valid SHALL NOT drop mid-frame.
REQ-029 A done rising edge seen in STREAM SHALL be ignored and SHALL set overrun; the frame in progress is unaffected.
REQ-030 A done rising edge in the same cycle as the idx-15 transfer SHALL be treated as occurring in STREAM: it is not captured and it sets overrun.
REQ-031 clr_overrun SHALL clear overrun; if a set and a clear occur in the same cycle, the set wins.
REQ-032 When out_valid = 0, out_data, out_row, out_col and out_last SHALL be 0.
REQ-033 done held high SHALL trigger only one capture; a new capture requires done to go low and then high again.

Reset
REQ-034 While _reset = 1, the module SHALL force state IDLE, idx 0, the previous-done register 0 and every output 0 (out_valid, out_data, out_row, out_col, out_last, frame_done, busy, overrun).
REQ-035 Reset asserted mid-frame SHALL abort the frame; no further beats are produced and frame_done does not pulse.
REQ-036 If done is already 1 when reset releases, the module SHALL capture on the first cycle after release (the previous-done register is 0), then obey REQ-033.

Verification
REQ-037 Basic frame: int[0][0] = 0x0001, frac1[0][0] = 0x0010, frac2[0][0] = 0x0020, all other elements 0, out_ready = 1, done rises -> beat 0 is 0x0000130 at row 0, col 0; 15 more zero beats follow on consecutive cycles; out_last on beat 15; frame_done one cycle later.
REQ-038 Sign: int[1][2] = 0xFFFF, frac1[1][2] = 0x0080, frac2[1][2] = 0x0000 -> beat 6 is 0x1FFFF80 (-128), row 1, col 2.
REQ-039 Backpressure: out_ready = 0 for 3 cycles while beat 5 is presented -> beat 5 is held unchanged for those 3 cycles; all 16 beats are delivered in order.
REQ-040 Overrun: done falls and rises again at beat 8 -> overrun = 1; remaining beats come from the original capture; clr_overrun pulse -> overrun = 0.
REQ-041 Reset mid-frame: _reset pulsed at beat 7 -> all outputs 0 on the next cycle; the next done edge restarts at row 0, col 0.
REQ-042 Level hold: done held at 1 across two complete frames' worth of cycles -> exactly one frame is produced and overrun stays 0.
